// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default sizing for the pipeline controller
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;
   localparam int TIMEOUT_DEF = 64;
   localparam int CNT_W_DEF   = 16;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: RAW hazard detection in ID, load-use only when forwarding is present
module hazard_detect (
   input  logic       fwd_en,
   input  logic [3:0] id_src1,
   input  logic [3:0] id_src2,
   input  logic       id_src1_v,
   input  logic       id_two_src,
   input  logic [3:0] exe_dest,
   input  logic [3:0] mem_dest,
   input  logic       exe_wb_en,
   input  logic       exe_mem_r_en,
   input  logic       mem_wb_en,
   output logic       hazard
);
   logic exe_match, mem_match;
   // with forwarding only a load in EXE stalls; without it any pending write in EXE or MEM does
   always_comb begin
      exe_match = (id_src1_v && exe_dest == id_src1) || (id_two_src && exe_dest == id_src2);
      mem_match = (id_src1_v && mem_dest == id_src1) || (id_two_src && mem_dest == id_src2);
      hazard    = fwd_en ? (exe_mem_r_en && exe_match)
                         : ((exe_wb_en && exe_match) || (mem_wb_en && mem_match));
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: memory-wait FSM, branch/hazard arbitration and load/flush generation for the 5-stage core
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             fwd_en,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_src1_v,
   input  logic             id_two_src,
   input  logic [3:0]       exe_dest,
   input  logic [3:0]       mem_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             mem_start,
   output logic             pc_ld,
   output logic             if_id_ld,
   output logic             id_ex_ld,
   output logic             ex_mem_ld,
   output logic             mem_wb_ld,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   state_t      state, state_nx;
   logic [15:0] wait_cnt;
   logic        mem_stall, start_raw, hazard;

   hazard_detect u_hazard (
      .fwd_en       (fwd_en),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_src1_v    (id_src1_v),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .mem_dest     (mem_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_wb_en    (mem_wb_en),
      .hazard       (hazard)
   );

   assign mem_err = (state == ST_ERR);

   // memory handshake: start access in RUN, hold stall until ready, give up after TIMEOUT wait cycles
   always_comb begin
      state_nx  = state;
      mem_stall = 1'b0;
      start_raw = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_req) begin
               start_raw = 1'b1;
               mem_stall = 1'b1;
               state_nx  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_ready) state_nx = ST_RUN;
            else begin
               mem_stall = 1'b1;
               if (wait_cnt == 16'(TIMEOUT - 1)) state_nx = ST_ERR;
            end
         end
         default: mem_stall = 1'b1;
      endcase
   end

   // priority mux: memory stall over taken branch over data hazard; everything held low in reset
   always_comb begin
      pc_ld        = 1'b1;
      if_id_ld     = 1'b1;
      id_ex_ld     = 1'b1;
      ex_mem_ld    = 1'b1;
      mem_wb_ld    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      mem_start    = start_raw;
      if (mem_stall) begin
         pc_ld        = 1'b0;
         if_id_ld     = 1'b0;
         id_ex_ld     = 1'b0;
         ex_mem_ld    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hazard) begin
         pc_ld       = 1'b0;
         if_id_ld    = 1'b0;
         id_ex_flush = 1'b1;
      end
      if (!RST_N) begin
         pc_ld        = 1'b0;
         if_id_ld     = 1'b0;
         id_ex_ld     = 1'b0;
         ex_mem_ld    = 1'b0;
         mem_wb_ld    = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         mem_wb_flush = 1'b0;
         mem_start    = 1'b0;
      end
   end

   // state, wait counter (restarts on every entry to WAIT) and saturating performance counters
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= (state == ST_WAIT) ? wait_cnt + 16'd1 : '0;
         if (!pc_ld && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of hazard, branch, memory-wait, timeout and counter saturation
module tb_pipe_ctrl;
   logic       CLK = 1'b0;
   logic       RST_N;
   logic       fwd_en, id_src1_v, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       branch_taken, mem_req, mem_ready;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       mem_start, pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld;
   logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
   logic [3:0] stall_cnt, flush_cnt;
   logic [8:0] ctl;
   int         n_cmp = 0;
   int         n_err = 0;

   // ctl = {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id/id_ex/mem_wb flush, mem_start}
   localparam logic [8:0] C_NORM  = 9'b11111_000_0;
   localparam logic [8:0] C_HAZ   = 9'b00111_010_0;
   localparam logic [8:0] C_BR    = 9'b11111_110_0;
   localparam logic [8:0] C_START = 9'b00001_001_1;
   localparam logic [8:0] C_STALL = 9'b00001_001_0;
   localparam logic [8:0] C_OFF   = 9'b00000_000_0;

   assign ctl = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_flush, id_ex_flush, mem_wb_flush, mem_start};

   always #5 CLK = ~CLK;

   pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .fwd_en(fwd_en),
      .id_src1(id_src1), .id_src2(id_src2), .id_src1_v(id_src1_v), .id_two_src(id_two_src),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .mem_start(mem_start),
      .pc_ld(pc_ld), .if_id_ld(if_id_ld), .id_ex_ld(id_ex_ld), .ex_mem_ld(ex_mem_ld),
      .mem_wb_ld(mem_wb_ld), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle;
      fwd_en = 1'b1; id_src1_v = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0;
      exe_mem_r_en = 1'b0; mem_wb_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
      mem_ready = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
   endtask

   task automatic do_reset;
      idle();
      RST_N = 1'b0;
      step();
      step();
      RST_N = 1'b1;
   endtask

   task automatic test_reset;
      idle();
      RST_N = 1'b0; mem_req = 1'b1; branch_taken = 1'b1;
      step();
      #1;
      n_cmp++; if (ctl !== C_OFF) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_OFF); end
      step();
      n_cmp++; if ({mem_err, stall_cnt, flush_cnt} !== 9'd0) begin n_err++; $display("FAIL reset_state got err=%b stall=%0d flush=%0d want 0", mem_err, stall_cnt, flush_cnt); end
      idle();
      RST_N = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL reset_release got %b want %b", ctl, C_NORM); end
   endtask

   task automatic test_load_use;
      do_reset();
      exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; id_src1_v = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_HAZ) begin n_err++; $display("FAIL load_use got %b want %b", ctl, C_HAZ); end
      step();
      idle();
      exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; id_src1_v = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL fwd_alu_no_stall got %b want %b", ctl, C_NORM); end
      n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
      step();
   endtask

   task automatic test_no_fwd;
      do_reset();
      fwd_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd5; id_two_src = 1'b1; id_src2 = 4'd5;
      #1;
      n_cmp++; if (ctl !== C_HAZ) begin n_err++; $display("FAIL nofwd_src2 got %b want %b", ctl, C_HAZ); end
      id_two_src = 1'b0;
      #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL nofwd_src2_unused got %b want %b", ctl, C_NORM); end
      mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 4'd7; id_src1 = 4'd7; id_src1_v = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_HAZ) begin n_err++; $display("FAIL nofwd_exe got %b want %b", ctl, C_HAZ); end
      id_src1 = 4'd6;
      #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL nofwd_exe_diff got %b want %b", ctl, C_NORM); end
      step();
   endtask

   task automatic test_branch;
      do_reset();
      branch_taken = 1'b1;
      exe_mem_r_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2; id_src1_v = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL branch got %b want %b", ctl, C_BR); end
      step();
      idle();
      #1;
      n_cmp++; if ({stall_cnt, flush_cnt} !== {4'd0, 4'd1}) begin n_err++; $display("FAIL branch_cnt got stall=%0d flush=%0d want 0/1", stall_cnt, flush_cnt); end
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL branch_after got %b want %b", ctl, C_NORM); end
   endtask

   task automatic test_memory;
      do_reset();
      mem_req = 1'b1; branch_taken = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_START) begin n_err++; $display("FAIL mem_start got %b want %b", ctl, C_START); end
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if ({ctl, mem_err} !== {C_STALL, 1'b0}) begin n_err++; $display("FAIL mem_wait%0d got %b err=%b want %b", i, ctl, mem_err, C_STALL); end
         step();
      end
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL mem_ready_branch got %b want %b", ctl, C_BR); end
      step();
      idle();
      #1;
      n_cmp++; if ({ctl, mem_err} !== {C_NORM, 1'b0}) begin n_err++; $display("FAIL mem_done got %b err=%b want %b err=0", ctl, mem_err, C_NORM); end
      n_cmp++; if ({stall_cnt, flush_cnt} !== {4'd4, 4'd1}) begin n_err++; $display("FAIL mem_cnt got stall=%0d flush=%0d want 4/1", stall_cnt, flush_cnt); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      mem_req = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_START) begin n_err++; $display("FAIL b2b_first got %b want %b", ctl, C_START); end
      step();
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL b2b_ready got %b want %b", ctl, C_NORM); end
      step();
      mem_ready = 1'b0;
      #1;
      n_cmp++; if (ctl !== C_START) begin n_err++; $display("FAIL b2b_second got %b want %b", ctl, C_START); end
      step();
      mem_ready = 1'b1;
      step();
      idle();
      #1;
      n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL b2b_cnt got %0d want 2", stall_cnt); end
   endtask

   task automatic test_timeout;
      do_reset();
      mem_req = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if ({ctl, mem_err} !== {C_STALL, 1'b0}) begin n_err++; $display("FAIL to_wait%0d got %b err=%b want %b err=0", i, ctl, mem_err, C_STALL); end
         step();
      end
      #1;
      n_cmp++; if ({ctl, mem_err} !== {C_STALL, 1'b1}) begin n_err++; $display("FAIL to_err got %b err=%b want %b err=1", ctl, mem_err, C_STALL); end
      mem_ready = 1'b1;
      step();
      step();
      n_cmp++; if ({pc_ld, mem_err} !== 2'b01) begin n_err++; $display("FAIL to_sticky got pc_ld=%b err=%b want 0/1", pc_ld, mem_err); end
      RST_N = 1'b0;
      step();
      idle();
      RST_N = 1'b1;
      #1;
      n_cmp++; if ({ctl, mem_err} !== {C_NORM, 1'b0}) begin n_err++; $display("FAIL to_clear got %b err=%b want %b err=0", ctl, mem_err, C_NORM); end
   endtask

   task automatic test_reset_mid_wait;
      do_reset();
      mem_req = 1'b1;
      step();
      step();
      step();
      step();
      RST_N = 1'b0;
      #1;
      n_cmp++; if (ctl !== C_OFF) begin n_err++; $display("FAIL rmw_forced got %b want %b", ctl, C_OFF); end
      step();
      RST_N = 1'b1;
      #1;
      n_cmp++; if ({ctl, stall_cnt} !== {C_START, 4'd0}) begin n_err++; $display("FAIL rmw_restart got %b stall=%0d want %b stall=0", ctl, stall_cnt, C_START); end
      step();
      step();
      step();
      step();
      #1;
      n_cmp++; if ({ctl, mem_err} !== {C_STALL, 1'b0}) begin n_err++; $display("FAIL rmw_cnt_cleared got %b err=%b want %b err=0", ctl, mem_err, C_STALL); end
      step();
   endtask

   task automatic test_saturation;
      do_reset();
      fwd_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 4'd9; id_src1 = 4'd9; id_src1_v = 1'b1;
      repeat (20) step();
      idle();
      branch_taken = 1'b1;
      repeat (20) step();
      idle();
      #1;
      n_cmp++; if ({stall_cnt, flush_cnt} !== {4'd15, 4'd15}) begin n_err++; $display("FAIL saturate got stall=%0d flush=%0d want 15/15", stall_cnt, flush_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      RST_N = 1'b0;
      step();
      test_reset();
      test_load_use();
      test_no_fwd();
      test_branch();
      test_memory();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage ARM-subset core: produces the load-enable (freeze_N-style, active-high load) and flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It arbitrates between three stall/flush sources: memory-stage waits (handshake with the SRAM controller), taken branches resolved in EXE, and RAW data hazards detected in ID. It also keeps a memory-timeout error flag and two saturating performance counters. Sits at core top level beside the hazard/forwarding logic.

## Interface
- TIMEOUT, 64: max WAIT cycles before mem_err; legal 2..65535.
- CNT_W, 16: performance counter width.

- CLK  in  1  clock; all state rising-edge.
- RST_N  in  1  one clock; reset is synchronous and active-low.
- fwd_en  in  1  1 = forwarding present (only load-use stalls).
- id_src1, id_src2  in  4 each  ID-stage source register numbers.
- id_src1_v, id_two_src  in  1 each  src1 used / src2 used.
- exe_dest, mem_dest  in  4 each  destination register in EXE / MEM.
- exe_wb_en, exe_mem_r_en, mem_wb_en  in  1 each  stage control bits.
- branch_taken  in  1  B bit of instruction in EXE.
- mem_req  in  1  MEM_R_EN | MEM_W_EN of instruction in MEM.
- mem_ready  in  1  SRAM controller access complete (1-cycle pulse).
- mem_start  out  1  1-cycle pulse starting an SRAM access.
- pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  synchronous clear (clear overrides load in the register).
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- FSM states RUN, WAIT, ERR (encoding in package).
- RUN: mem_req=1 -> mem_start=1, mem_stall=1, next WAIT. Otherwise mem_stall=0.
- WAIT: mem_stall=1 unless mem_ready=1; on mem_ready -> mem_stall=0 this cycle, next RUN. wait_cnt increments each WAIT cycle; wait_cnt reaching TIMEOUT-1 with mem_ready=0 -> next ERR. mem_ready in same cycle as timeout wins (go RUN).
- ERR: mem_err=1, mem_stall=1 forever until reset. mem_ready ignored.
- hazard (fwd_en=1): exe_mem_r_en & ((id_src1_v & exe_dest==id_src1) | (id_two_src & exe_dest==id_src2)).
- hazard (fwd_en=0): same matches qualified by exe_wb_en against exe_dest, OR by mem_wb_en against mem_dest.
- Priority, per cycle:
  - mem_stall: pc/if_id/id_ex/ex_mem ld=0, mem_wb_ld=1, mem_wb_flush=1 (bubble into WB); branch and hazard ignored (branch stays in EXE, reapplied when stall ends).
  - else branch_taken: all ld=1, if_id_flush=1, id_ex_flush=1; hazard ignored.
  - else hazard: pc_ld=0, if_id_ld=0, id_ex_flush=1 (ld=1), ex_mem/mem_wb ld=1.
  - else: all ld=1, all flush=0.
- stall_cnt +1 each cycle with pc_ld=0 (state RUN/WAIT/ERR); flush_cnt +1 each cycle with if_id_flush=1; both saturate at all-ones.

## Timing
- Reset (RST_N=0 at edge): state RUN, wait_cnt 0, mem_err 0, counters 0. While RST_N=0 all ld, flush, mem_start outputs forced 0.
- Controls are Mealy: combinational from state and current inputs, same-cycle effect on register loads.
- Memory access minimum cost: 1 stall cycle (mem_ready in first WAIT cycle) + SRAM latency; mem_start exactly once per access.
- Back-to-back memory instructions: after mem_ready, next MEM occupant raises mem_req in following RUN cycle -> new mem_start.
- Reset mid-WAIT: access abandoned, no mem_start, wait_cnt cleared.

## Structure
- Package pipe_ctrl_pkg: state enum, default TIMEOUT/CNT_W constants.
- Sub-module hazard_detect (combinational, fwd_en-selectable); FSM, counters, priority mux in pipe_ctrl.

## Test plan
- Load-use, fwd_en=1: exe_mem_r_en=1, exe_dest=3, id_src1=3, v=1 -> 1 cycle pc_ld=if_id_ld=0, id_ex_flush=1; stall_cnt=1.
- fwd_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 -> stall; same with id_two_src=0 -> no stall.
- Branch: branch_taken=1, no stall -> if_id_flush=id_ex_flush=1 one cycle, all ld=1, flush_cnt=1.
- Memory: mem_req=1, mem_ready after 3 cycles -> mem_start one pulse, 4 stall cycles, mem_wb_flush=1 each, then RUN; simultaneous branch_taken flush only after stall.
- Timeout TIMEOUT=4, mem_ready never -> ERR after 4 WAIT cycles, mem_err=1 held, pc_ld=0; RST_N=0 clears.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15.
